// File: rtl/miu_arb.sv
// miu_arb: multi-channel IU memory interface unit.
// Round-robin arbitrates NUM_CH level-held IU requests onto one cache
// request channel, keeps up to MAX_OUT transactions in flight, and routes
// the in-order cache responses back through an {id, we} ordering FIFO.
// Optional build macro MIU_XCHECK_EN: skip channels whose request fields
// are not fully known (simulation X filtering).
module miu_arb #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int MAX_OUT = 4
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic [NUM_CH-1:0]              mem_req,
  input  logic [NUM_CH-1:0]              mem_we,
  input  logic [NUM_CH*ADDR_W-1:0]       mem_addr,
  input  logic [NUM_CH*DATA_W-1:0]       mem_write,
  output logic [NUM_CH*DATA_W-1:0]       mem_read,
  output logic [NUM_CH-1:0]              mem_done,
  output logic                           cache_req_valid,
  input  logic                           cache_req_ready,
  output logic                           cache_req_we,
  output logic [ADDR_W-1:0]              cache_req_addr,
  output logic [DATA_W-1:0]              cache_req_write,
  input  logic                           cache_resp_valid,
  input  logic [DATA_W-1:0]              cache_resp_data,
  output logic [$clog2(MAX_OUT+1)-1:0]   outstanding,
  output logic                           err_unexp_resp
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [NUM_CH-1:0] holdoff;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] fields_ok;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] gnt_vec;
  logic [NUM_CH-1:0] done_vec;

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   arb_sel;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt;
  logic              slot_free;
  logic              fifo_full;
  logic              fifo_empty;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_write;

  logic [ID_W-1:0]    fifo_id [MAX_OUT];
  logic [MAX_OUT-1:0] fifo_we;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ID_W-1:0]    head_id;
  logic               head_we;
  logic               resp_pop;

`ifdef MIU_XCHECK_EN
  // A channel only competes once its we/addr/write fields are fully known.
  always_comb begin
    fields_ok = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fields_ok[i] = ((mem_we[i] === 1'b0) || (mem_we[i] === 1'b1)) &&
                     ((^mem_addr[i*ADDR_W +: ADDR_W]) !== 1'bx) &&
                     ((^mem_write[i*DATA_W +: DATA_W]) !== 1'bx);
    end
  end
`else
  assign fields_ok = '1;
`endif

  assign eligible   = mem_req & ~holdoff & ~pending & fields_ok;
  assign fifo_full  = (outstanding == OUT_W'(MAX_OUT));
  assign fifo_empty = (outstanding == '0);
  assign slot_free  = ~cache_req_valid | cache_req_ready;
  assign head_id    = fifo_id[rd_ptr];
  assign head_we    = fifo_we[rd_ptr];
  assign resp_pop   = cache_resp_valid & ~fifo_empty;

  // Round-robin search starting at rr_ptr; a full FIFO or busy slot blocks grants.
  always_comb begin
    gnt     = 1'b0;
    gnt_id  = '0;
    arb_sel = '0;
    if (slot_free && !fifo_full) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if ((int'(rr_ptr) + k) >= NUM_CH)
          arb_sel = ID_W'(int'(rr_ptr) + k - NUM_CH);
        else
          arb_sel = ID_W'(int'(rr_ptr) + k);
        if (!gnt && eligible[arb_sel]) begin
          gnt    = 1'b1;
          gnt_id = arb_sel;
        end
      end
    end
  end

  // Decode grant/response ids and mux the granted channel's request fields.
  always_comb begin
    gnt_vec   = '0;
    done_vec  = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_write = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_id == ID_W'(i)) begin
        gnt_vec[i] = gnt;
        sel_we     = mem_we[i];
        sel_addr   = mem_addr[i*ADDR_W +: ADDR_W];
        sel_write  = mem_write[i*DATA_W +: DATA_W];
      end
      if (head_id == ID_W'(i))
        done_vec[i] = resp_pop;
    end
  end

  // Request slot: loads on grant, holds until the cache accepts it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cache_req_valid <= 1'b0;
      cache_req_we    <= 1'b0;
      cache_req_addr  <= '0;
      cache_req_write <= '0;
    end else if (gnt) begin
      cache_req_valid <= 1'b1;
      cache_req_we    <= sel_we;
      cache_req_addr  <= sel_addr;
      cache_req_write <= sel_write;
    end else if (cache_req_ready) begin
      cache_req_valid <= 1'b0;
    end
  end

  // Ordering FIFO storage; entries are only read while valid, so no reset.
  always_ff @(posedge clk) begin
    if (gnt) begin
      fifo_id[wr_ptr] <= gnt_id;
      fifo_we[wr_ptr] <= sel_we;
    end
  end

  // Transaction bookkeeping: pointers, in-flight count, per-channel flags, error.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      outstanding    <= '0;
      pending        <= '0;
      holdoff        <= '0;
      rr_ptr         <= '0;
      err_unexp_resp <= 1'b0;
    end else begin
      if (gnt && !resp_pop)
        outstanding <= outstanding + OUT_W'(1);
      else if (!gnt && resp_pop)
        outstanding <= outstanding - OUT_W'(1);
      if (gnt) begin
        wr_ptr <= (wr_ptr == PTR_W'(MAX_OUT - 1)) ? '0 : wr_ptr + PTR_W'(1);
        rr_ptr <= (gnt_id == ID_W'(NUM_CH - 1)) ? '0 : gnt_id + ID_W'(1);
      end
      if (resp_pop)
        rd_ptr <= (rd_ptr == PTR_W'(MAX_OUT - 1)) ? '0 : rd_ptr + PTR_W'(1);
      pending <= (pending | gnt_vec) & ~done_vec;
      holdoff <= (holdoff | gnt_vec) & mem_req;
      if (cache_resp_valid && fifo_empty)
        err_unexp_resp <= 1'b1;
    end
  end

  // Response return: capture load data and pulse done for the head requester.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mem_read <= '0;
      mem_done <= '0;
    end else begin
      mem_done <= done_vec;
      for (int i = 0; i < NUM_CH; i++) begin
        if (done_vec[i] && !head_we)
          mem_read[i*DATA_W +: DATA_W] <= cache_resp_data;
      end
    end
  end

endmodule
